wb_regfile: RTL and testbench
=============================

# wb_regfile

Register file that receives the write-back stage's result in the 5-stage MIPS pipeline. It accepts the selected write-back data, destination register and write enable, commits them on the clock edge, and serves two combinational read ports to the decode stage, with same-cycle write-through bypass. It also keeps a debug record of the last committed write and a saturating count of committed writes for testbench `$display` tracing.

## Interface
- `DATA_W`, default 32: register and data width.
- `ADDR_W`, default 5: register index width; depth is 2^ADDR_W = 32 registers.
- `CNT_W`, default 16: width of the committed-write counter.

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wb_data`  in  DATA_W  write-back data, i.e. the write-back mux output (memory data or ALU result).
- `wb_reg`  in  ADDR_W  destination register index.
- `wb_regwrite`  in  1  write enable from the write-back control bits.
- `rs_addr`  in  ADDR_W  read port A index.
- `rt_addr`  in  ADDR_W  read port B index.
- `rs_data`  out  DATA_W  read port A data, combinational.
- `rt_data`  out  DATA_W  read port B data, combinational.
- `last_wr_reg`  out  ADDR_W  index of the most recent committed write.
- `last_wr_data`  out  DATA_W  data of the most recent committed write.
- `wr_count`  out  CNT_W  number of committed writes, saturating.

## Operation
- A write is committed when `wb_regwrite`=1 and `wb_reg`≠0 at a rising `clk` edge. The edge sets `regs[wb_reg]`←`wb_data`, `last_wr_reg`←`wb_reg`, `last_wr_data`←`wb_data` and `wr_count`←`wr_count`+1.
- `wr_count` saturates at 2^CNT_W−1 and does not wrap.
- Register 0 is hardwired to zero:
  - A write to index 0 is discarded.
  - Such a write does not update `last_wr_*` or `wr_count`.
  - A read of index 0 always returns 0, including while a write to index 0 is in progress.
- Each read port returns, in priority order:
  1. 0 if its address is 0.
  2. `wb_data` if `wb_regwrite`=1 and `wb_reg` equals its address. This is write-through bypass, so decode sees the value being written in the same cycle.
  3. `regs[addr]` otherwise.
- Both read ports may address the same register. Each resolves independently and returns identical data.
- `wb_regwrite`=0 leaves all state unchanged, whatever `wb_reg` and `wb_data` hold.
- Write data is stored full-width with no sign or zero manipulation.

## Timing
- Write latency: data is stored at the rising edge where the enable is sampled. With bypass it is visible on the read ports combinationally in that same cycle, and from the array on every later cycle.
- Read latency: zero cycles. The ports are purely combinational from `rs_addr`, `rt_addr`, `wb_*` and array state.
- Reset: `rst_n` low immediately forces every `regs[i]`, `last_wr_reg`, `last_wr_data` and `wr_count` to 0, with no clock needed.
  - `rs_data` and `rt_data` therefore read 0 for any address, unless the bypass condition is active.
- Reset mid-operation: a write coincident with `rst_n` low is lost.
- Reset release: the first write can commit on the first rising edge after `rst_n` goes high.
- Back-to-back writes to the same register on consecutive edges are allowed. The later one wins.

## Test plan
- Reset clear: write `32'h002300AA` to r5, then pulse `rst_n` low between edges. r5, `last_wr_data` and `wr_count` must all be 0 immediately, before the next edge.
- Basic write/read: write `32'h8C123456` to r8, then `32'hAD654321` to r9 on consecutive edges. Then `rs_addr`=8 must give `32'h8C123456`, `rt_addr`=9 must give `32'hAD654321`, and `wr_count`=2.
- Bypass: drive `wb_reg`=12, `wb_data`=`32'h13012345`, `wb_regwrite`=1, `rs_addr`=`rt_addr`=12 between edges. Both ports must show `32'h13012345` before the edge, and still show it after the edge with `wb_regwrite`=0.
- r0 protection: write `32'h12012345` to r0. `rs_addr`=0 must give 0 before and after the edge, and `wr_count` and `last_wr_reg` must be unchanged.
- Disabled write: drive `wb_regwrite`=0, `wb_reg`=3, `wb_data`=`32'hAC654321` for several edges. r3 must stay at its prior value and `wr_count` must be unchanged.
- Counter saturation (CNT_W=4): perform 20 writes to r1. `wr_count` must stop at 15 and `last_wr_data` must equal the 20th value.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back register file: r0 hardwired to zero, two combinational read ports
// with same-cycle write-through bypass, plus last-write trace and saturating write count.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [ADDR_W-1:0] last_wr_reg,
  output logic [DATA_W-1:0] last_wr_data,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [ADDR_W-1:0] last_wr_reg_q;
  logic [DATA_W-1:0] last_wr_data_q;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic              commit;

  assign commit = wb_regwrite && (wb_reg != '0);

  always_comb begin
    wr_count_d = wr_count_q;
    if (commit && (wr_count_q != '1)) begin
      wr_count_d = wr_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      last_wr_reg_q  <= '0;
      last_wr_data_q <= '0;
      wr_count_q     <= '0;
    end else begin
      if (commit) begin
        regs_q[wb_reg] <= wb_data;
        last_wr_reg_q  <= wb_reg;
        last_wr_data_q <= wb_data;
      end
      wr_count_q <= wr_count_d;
    end
  end

  // Zero check takes priority so a write aimed at r0 never leaks through the bypass.
  always_comb begin
    rs_data = regs_q[rs_addr];
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (wb_regwrite && (wb_reg == rs_addr)) begin
      rs_data = wb_data;
    end
  end

  always_comb begin
    rt_data = regs_q[rt_addr];
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (wb_regwrite && (wb_reg == rt_addr)) begin
      rt_data = wb_data;
    end
  end

  assign last_wr_reg  = last_wr_reg_q;
  assign last_wr_data = last_wr_data_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile (CNT_W=4 so counter saturation is reachable quickly).
module tb_wb_regfile;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_reg;
  logic              wb_regwrite;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [ADDR_W-1:0] last_wr_reg;
  logic [DATA_W-1:0] last_wr_data;
  logic [CNT_W-1:0]  wr_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_data      (wb_data),
    .wb_reg       (wb_reg),
    .wb_regwrite  (wb_regwrite),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .last_wr_reg  (last_wr_reg),
    .last_wr_data (last_wr_data),
    .wr_count     (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    wb_reg = r; wb_data = d; wb_regwrite = 1'b1;
    tick();
    wb_regwrite = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wb_data = '0; wb_reg = '0; wb_regwrite = 1'b0;
    rs_addr = '0; rt_addr = '0;
    #12;
    rs_addr = 5'd5; rt_addr = 5'd31;
    #1;
    chk("reset_rs5", rs_data, 32'h0);
    chk("reset_rt31", rt_data, 32'h0);
    chk("reset_cnt", 32'(wr_count), 32'd0);
    chk("reset_last_reg", 32'(last_wr_reg), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset clear between edges
    wr(5'd5, 32'h002300AA);
    chk("pre_rst_r5", rs_data, 32'h002300AA);
    chk("pre_rst_cnt", 32'(wr_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_r5", rs_data, 32'h0);
    chk("async_rst_last_data", last_wr_data, 32'h0);
    chk("async_rst_cnt", 32'(wr_count), 32'd0);
    #1 rst_n = 1'b1;

    // Basic write/read, first write right after release
    wr(5'd8, 32'h8C123456);
    wr(5'd9, 32'hAD654321);
    rs_addr = 5'd8; rt_addr = 5'd9;
    #1;
    chk("basic_rs8", rs_data, 32'h8C123456);
    chk("basic_rt9", rt_data, 32'hAD654321);
    chk("basic_cnt", 32'(wr_count), 32'd2);
    chk("basic_last_reg", 32'(last_wr_reg), 32'd9);
    chk("basic_last_data", last_wr_data, 32'hAD654321);

    // Bypass on both ports
    wb_reg = 5'd12; wb_data = 32'h13012345; wb_regwrite = 1'b1;
    rs_addr = 5'd12; rt_addr = 5'd12;
    #1;
    chk("bypass_rs_pre", rs_data, 32'h13012345);
    chk("bypass_rt_pre", rt_data, 32'h13012345);
    tick();
    wb_regwrite = 1'b0; wb_data = 32'hDEADBEEF;
    #1;
    chk("bypass_rs_post", rs_data, 32'h13012345);
    chk("bypass_rt_post", rt_data, 32'h13012345);
    chk("bypass_cnt", 32'(wr_count), 32'd3);

    // r0 protection
    wb_reg = 5'd0; wb_data = 32'h12012345; wb_regwrite = 1'b1;
    rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    chk("r0_rs_pre", rs_data, 32'h0);
    chk("r0_rt_pre", rt_data, 32'h0);
    tick();
    wb_regwrite = 1'b0;
    #1;
    chk("r0_rs_post", rs_data, 32'h0);
    chk("r0_cnt", 32'(wr_count), 32'd3);
    chk("r0_last_reg", 32'(last_wr_reg), 32'd12);

    // Disabled write leaves state alone
    wr(5'd3, 32'h11111111);
    wb_reg = 5'd3; wb_data = 32'hAC654321; wb_regwrite = 1'b0;
    rt_addr = 5'd3;
    #1;
    chk("dis_rt3_pre", rt_data, 32'h11111111);
    tick(); tick(); tick();
    chk("dis_rt3_post", rt_data, 32'h11111111);
    chk("dis_cnt", 32'(wr_count), 32'd4);
    chk("dis_last_data", last_wr_data, 32'h11111111);

    // Back-to-back writes to one register: later wins
    wr(5'd8, 32'h0000AAAA);
    wr(5'd8, 32'h0000BBBB);
    rs_addr = 5'd8;
    #1;
    chk("b2b_rs8", rs_data, 32'h0000BBBB);
    chk("b2b_cnt", 32'(wr_count), 32'd6);

    // Write coincident with reset is lost
    rst_n = 1'b0;
    wb_reg = 5'd2; wb_data = 32'h55555555; wb_regwrite = 1'b1;
    tick();
    wb_regwrite = 1'b0;
    rst_n = 1'b1;
    rs_addr = 5'd2;
    #1;
    chk("rst_write_lost", rs_data, 32'h0);
    chk("rst_write_cnt", 32'(wr_count), 32'd0);

    // Saturation: 20 writes to r1
    for (int i = 0; i < 20; i++) begin
      wr(5'd1, 32'h10000000 + 32'(i));
      if (i == 14) chk("sat_cnt_15", 32'(wr_count), 32'd15);
    end
    rs_addr = 5'd1;
    #1;
    chk("sat_cnt_hold", 32'(wr_count), 32'd15);
    chk("sat_last_data", last_wr_data, 32'h10000013);
    chk("sat_rs1", rs_data, 32'h10000013);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
